// File: rtl/serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_pkg
// Shared types and constants for the serial out buffer sharing logic.
//   tx_state_e           : arbiter FSM states
//   FRAME_BITS           : bits in one serial frame on the line
//   DEFAULT_FRAME_CYCLES : Go pulse to transmitter idle (frame + latency + margin)
//   DEFAULT_GAP_CYCLES   : idle cycles forced between two frames
//   clog2 / max2         : elaboration-time helpers for sizing counters/indices
// ---------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS           = 19;
  // One extra cycle for the transmitter output register, one for margin.
  localparam int DEFAULT_FRAME_CYCLES = FRAME_BITS + 2;
  localparam int DEFAULT_GAP_CYCLES   = 2;

  // Ceiling log2, never smaller than 1 so a 2-entry index still gets a bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker, reusable by any block that shares
// a resource between NUM_REQ clients.
//   req    : request vector, one bit per client
//   rr_ptr : index that has highest priority this round
//   winner : first set req bit at or above rr_ptr, wrapping past NUM_REQ-1
//   valid  : at least one request is set (winner is meaningless otherwise)
// ---------------------------------------------------------------------------
module rr_arbiter
  import serial_tx_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Walk the offsets from the farthest back to the nearest so that the last
  // hit written is the one closest to rr_ptr; this avoids a break statement
  // and keeps the loop a plain priority chain for synthesis.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req[idx[IDX_W-1:0]]) begin
        winner = idx[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
// Shares one serial out buffer (A + D words, Go-started frame) between
// NUM_REQ requesters. Grants in round-robin order, latches the winner's
// words, pulses Go, times the frame by counting cycles, then enforces an
// idle gap before the next grant. All outputs are registered.
//   clk_in   : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   req      : level request per requester, held with stable data until ack
//   a_in     : packed A words, requester i at [i*SIZE_A +: SIZE_A]
//   d_in     : packed D words, same packing
//   ack      : one-cycle pulse, request captured and data may change
//   done     : one-cycle pulse, that requester's frame has left the line
//   tx_go    : one-cycle Go pulse to the serial out buffer
//   tx_a     : latched A word to the transmitter
//   tx_d     : latched D word to the transmitter
//   busy     : high in every state except IDLE
//   grant_id : index of the current or most recent winner
// ---------------------------------------------------------------------------
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int SIZE_A       = 7,
  parameter  int SIZE_D       = 8,
  parameter  int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
  parameter  int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
  localparam int IDX_W        = clog2(NUM_REQ)
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SIZE_A-1:0]  a_in,
  input  logic [NUM_REQ*SIZE_D-1:0]  d_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic                       tx_go,
  output logic [SIZE_A-1:0]          tx_a,
  output logic [SIZE_D-1:0]          tx_d,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_id
);

  localparam int CNT_W = clog2(max2(FRAME_CYCLES, GAP_CYCLES) + 1);

  // LAUNCH already accounts for one cycle of the frame and the WAIT exit edge
  // for another, so WAIT counts down from FRAME_CYCLES-2 to zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  tx_state_e        state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W-1:0] arb_winner;
  logic             arb_valid;

  logic [SIZE_A-1:0] a_word [NUM_REQ];
  logic [SIZE_D-1:0] d_word [NUM_REQ];

  // Unpack the flat word buses once so the capture below is a simple mux.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_word[i] = a_in[i*SIZE_A +: SIZE_A];
    assign d_word[i] = d_in[i*SIZE_D +: SIZE_D];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Single FSM register block. Requests are only looked at in IDLE, so a
  // request raised mid-frame simply stays pending until the gap expires, and
  // one dropped before it is acked leaves no trace. grant_id is kept after
  // the frame so done can be routed back and software can see the last winner.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ack      <= '0;
      done     <= '0;
      tx_go    <= 1'b0;
      tx_a     <= '0;
      tx_d     <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack   <= '0;
          done  <= '0;
          tx_go <= 1'b0;
          busy  <= 1'b0;
          if (arb_valid) begin
            tx_a     <= a_word[arb_winner];
            tx_d     <= d_word[arb_winner];
            grant_id <= arb_winner;
            ack      <= idx_onehot(arb_winner);
            tx_go    <= 1'b1;
            busy     <= 1'b1;
            rr_ptr   <= (arb_winner == LAST_IDX) ? '0 : arb_winner + 1'b1;
            state    <= LAUNCH;
          end
        end

        LAUNCH: begin
          tx_go <= 1'b0;
          ack   <= '0;
          cnt   <= WAIT_LOAD;
          state <= WAIT;
        end

        WAIT: begin
          if (cnt == '0) begin
            done  <= idx_onehot(grant_id);
            cnt   <= GAP_LOAD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GAP: begin
          done <= '0;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_arbiter
// Directed bench for serial_tx_arbiter: a 4-requester instance for the main
// scenarios and a 3-requester instance for round-robin wrap-around. Expected
// grants are queued when requests are driven and popped on each tx_go.
// ---------------------------------------------------------------------------
module tb_serial_tx_arbiter;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int SA = 7;
  localparam int SD = 8;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;

  logic [N-1:0]    req;
  logic [N*SA-1:0] a_in;
  logic [N*SD-1:0] d_in;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic            tx_go;
  logic [SA-1:0]   tx_a;
  logic [SD-1:0]   tx_d;
  logic            busy;
  logic [1:0]      grant_id;

  logic [N3-1:0]    req3;
  logic [N3*SA-1:0] a3;
  logic [N3*SD-1:0] d3;
  logic [N3-1:0]    ack3;
  logic [N3-1:0]    done3;
  logic             tx_go3;
  logic [SA-1:0]    tx_a3;
  logic [SD-1:0]    tx_d3;
  logic             busy3;
  logic [1:0]       grant_id3;

  int vectors     = 0;
  int miscompares = 0;
  int goCount     = 0;
  int ackCount    = 0;

  typedef struct {
    int          id;
    logic [SA-1:0] a;
    logic [SD-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];

  always #5 clk_in = ~clk_in;

  serial_tx_arbiter #(
    .NUM_REQ (N)
  ) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .req      (req),
    .a_in     (a_in),
    .d_in     (d_in),
    .ack      (ack),
    .done     (done),
    .tx_go    (tx_go),
    .tx_a     (tx_a),
    .tx_d     (tx_d),
    .busy     (busy),
    .grant_id (grant_id)
  );

  serial_tx_arbiter #(
    .NUM_REQ (N3)
  ) dut3 (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .req      (req3),
    .a_in     (a3),
    .d_in     (d3),
    .ack      (ack3),
    .done     (done3),
    .tx_go    (tx_go3),
    .tx_a     (tx_a3),
    .tx_d     (tx_d3),
    .busy     (busy3),
    .grant_id (grant_id3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants: one-hot pulses, Go only while busy, words frozen
  // for the whole time the transmitter owns them.
  logic          prevBusy = 1'b0;
  logic [SA-1:0] prevA    = '0;
  logic [SD-1:0] prevD    = '0;

  always @(negedge clk_in) begin
    checkOutput("onehot0_ack", 32'($onehot0(ack)), 32'd1);
    checkOutput("onehot0_done", 32'($onehot0(done)), 32'd1);
    checkOutput("onehot0_ack3", 32'($onehot0(ack3)), 32'd1);
    if (tx_go === 1'b1) begin
      checkOutput("go_implies_busy", 32'(busy), 32'd1);
      goCount++;
    end
    if (ack !== '0) begin
      ackCount++;
    end
    if (busy === 1'b1 && prevBusy === 1'b1) begin
      checkOutput("tx_a_stable", 32'(tx_a), 32'(prevA));
      checkOutput("tx_d_stable", 32'(tx_d), 32'(prevD));
    end
    prevBusy = busy;
    prevA    = tx_a;
    prevD    = tx_d;
  end

  task automatic applyStimulus(input logic [N-1:0] r);
    req = r;
  endtask

  task automatic applyStimulus3(input logic [N3-1:0] r);
    req3 = r;
  endtask

  task automatic setWord(input int i, input logic [SA-1:0] a, input logic [SD-1:0] d);
    a_in[i*SA +: SA] = a;
    d_in[i*SD +: SD] = d;
  endtask

  task automatic setWord3(input int i, input logic [SA-1:0] a, input logic [SD-1:0] d);
    a3[i*SA +: SA] = a;
    d3[i*SD +: SD] = d;
  endtask

  task automatic pushExp(input int id, input logic [SA-1:0] a, input logic [SD-1:0] d);
    exp_t e;
    e.id = id;
    e.a  = a;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic pushExp3(input int id, input logic [SA-1:0] a, input logic [SD-1:0] d);
    exp_t e;
    e.id = id;
    e.a  = a;
    e.d  = d;
    sb3.push_back(e);
  endtask

  task automatic waitGo(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (tx_go !== 1'b1 && n < 100);
    if (tx_go !== 1'b1) checkOutput("go_timeout", 32'(tx_go), 32'd1);
  endtask

  task automatic waitGo3(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (tx_go3 !== 1'b1 && n < 100);
    if (tx_go3 !== 1'b1) checkOutput("go3_timeout", 32'(tx_go3), 32'd1);
  endtask

  task automatic waitDone(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (done === '0 && n < 100);
    if (done === '0) checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (busy !== 1'b0 && n < 200);
    if (busy !== 1'b0) checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic waitIdle3(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (busy3 !== 1'b0 && n < 200);
    if (busy3 !== 1'b0) checkOutput("idle3_timeout", 32'(busy3), 32'd0);
  endtask

  // Pop the oldest expected grant and compare it with the launch outputs.
  task automatic checkGrant(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
      checkOutput({tag, "_tx_a"}, 32'(tx_a), 32'(e.a));
      checkOutput({tag, "_tx_d"}, 32'(tx_d), 32'(e.d));
      checkOutput({tag, "_ack"}, 32'(ack), 32'd1 << e.id);
    end
  endtask

  task automatic checkGrant3(input string tag);
    exp_t e;
    if (sb3.size() == 0) begin
      checkOutput({tag, "_sb3_empty"}, 32'(sb3.size()), 32'd1);
    end else begin
      e = sb3.pop_front();
      checkOutput({tag, "_grant_id"}, 32'(grant_id3), 32'(e.id));
      checkOutput({tag, "_tx_a"}, 32'(tx_a3), 32'(e.a));
      checkOutput({tag, "_tx_d"}, 32'(tx_d3), 32'(e.d));
      checkOutput({tag, "_ack"}, 32'(ack3), 32'd1 << e.id);
    end
  endtask

  initial begin
    int n;
    int gBefore;
    int aBefore;
    logic [SA-1:0] wa;
    logic [SD-1:0] wd;

    req  = '0;
    a_in = '0;
    d_in = '0;
    req3 = '0;
    a3   = '0;
    d3   = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_go", 32'(tx_go), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_tx_a", 32'(tx_a), 32'd0);
    checkOutput("rst_tx_d", 32'(tx_d), 32'd0);
    checkOutput("rst_busy3", 32'(busy3), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);
    checkOutput("idle_no_req_busy", 32'(busy), 32'd0);

    // Single request: latency, captured words, frame and gap timing
    $display("[TB] single request from requester 1");
    setWord(1, 7'h55, 8'hA3);
    applyStimulus(4'b0010);
    pushExp(1, 7'h55, 8'hA3);
    waitGo(n);
    checkOutput("t1_go_latency", 32'(n), 32'd1);
    checkGrant("t1");
    applyStimulus(4'b0000);
    waitDone(n);
    checkOutput("t1_done_latency", 32'(n), 32'd21);
    checkOutput("t1_done_bit", 32'(done), 32'b0010);
    waitIdle(n);
    checkOutput("t1_busy_fall", 32'(n), 32'd2);

    // All requesters held: round-robin order and frame spacing
    $display("[TB] all requesters held high");
    reset_n = 1'b0;
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < N; i++) begin
      wa = SA'(7'h10 + i * 7'h0B);
      wd = SD'(8'hC1 + i * 8'h13);
      setWord(i, wa, wd);
    end
    for (int k = 0; k < 5; k++) begin
      wa = SA'(7'h10 + (k % N) * 7'h0B);
      wd = SD'(8'hC1 + (k % N) * 8'h13);
      pushExp(k % N, wa, wd);
    end
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      waitGo(n);
      if (k == 0) checkOutput("t2_first_go", 32'(n), 32'd1);
      else        checkOutput("t2_go_spacing", 32'(n), 32'd24);
      checkGrant("t2");
    end
    applyStimulus(4'b0000);
    waitIdle(n);

    // Short pulse during WAIT is ignored; a held one is served after GAP
    $display("[TB] request pulsed versus held during a frame");
    setWord(0, 7'h2A, 8'h5C);
    applyStimulus(4'b0001);
    pushExp(0, 7'h2A, 8'h5C);
    waitGo(n);
    checkGrant("t3a");
    applyStimulus(4'b0000);
    repeat (5) @(negedge clk_in);
    gBefore = goCount;
    aBefore = ackCount;
    setWord(2, 7'h71, 8'h0F);
    applyStimulus(4'b0100);
    @(negedge clk_in);
    applyStimulus(4'b0000);
    waitIdle(n);
    repeat (30) @(negedge clk_in);
    checkOutput("t3_no_extra_go", 32'(goCount), 32'(gBefore));
    checkOutput("t3_no_extra_ack", 32'(ackCount), 32'(aBefore));

    setWord(1, 7'h33, 8'h99);
    applyStimulus(4'b0010);
    pushExp(1, 7'h33, 8'h99);
    waitGo(n);
    checkGrant("t3b");
    applyStimulus(4'b0000);
    repeat (5) @(negedge clk_in);
    setWord(2, 7'h71, 8'h0F);
    applyStimulus(4'b0100);
    pushExp(2, 7'h71, 8'h0F);
    waitGo(n);
    checkOutput("t3_held_go_delay", 32'(n), 32'd19);
    checkGrant("t3c");
    applyStimulus(4'b0000);
    waitIdle(n);

    // Reset mid-WAIT clears everything at once, and rr_ptr restarts at 0
    $display("[TB] asynchronous reset in the middle of a frame");
    setWord(0, 7'h44, 8'h12);
    applyStimulus(4'b0001);
    pushExp(0, 7'h44, 8'h12);
    waitGo(n);
    checkGrant("t4a");
    applyStimulus(4'b0000);
    repeat (10) @(negedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_busy", 32'(busy), 32'd0);
    checkOutput("t4_rst_tx_go", 32'(tx_go), 32'd0);
    checkOutput("t4_rst_done", 32'(done), 32'd0);
    checkOutput("t4_rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("t4_rst_tx_a", 32'(tx_a), 32'd0);
    checkOutput("t4_rst_tx_d", 32'(tx_d), 32'd0);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    setWord(0, 7'h0E, 8'hE0);
    setWord(1, 7'h1D, 8'hD1);
    applyStimulus(4'b0011);
    pushExp(0, 7'h0E, 8'hE0);
    waitGo(n);
    checkOutput("t4_go_latency", 32'(n), 32'd1);
    checkGrant("t4b");
    applyStimulus(4'b0000);
    waitDone(n);
    checkOutput("t4_done_latency", 32'(n), 32'd21);
    checkOutput("t4_done_bit", 32'(done), 32'b0001);
    waitIdle(n);
    checkOutput("t4_busy_fall", 32'(n), 32'd2);

    // Three requesters: after granting 2 the pointer wraps back to 0
    $display("[TB] three-requester wrap-around");
    setWord3(2, 7'h62, 8'h2B);
    applyStimulus3(3'b100);
    pushExp3(2, 7'h62, 8'h2B);
    waitGo3(n);
    checkOutput("t5_go_latency", 32'(n), 32'd1);
    checkGrant3("t5a");
    applyStimulus3(3'b000);
    waitIdle3(n);
    setWord3(0, 7'h05, 8'h50);
    setWord3(2, 7'h27, 8'h72);
    applyStimulus3(3'b101);
    pushExp3(0, 7'h05, 8'h50);
    pushExp3(2, 7'h27, 8'h72);
    waitGo3(n);
    checkOutput("t5_wrap_go_latency", 32'(n), 32'd1);
    checkGrant3("t5b");
    waitGo3(n);
    checkOutput("t5_go_spacing", 32'(n), 32'd24);
    checkGrant3("t5c");
    applyStimulus3(3'b000);
    waitIdle3(n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
